brew_sequencer: RTL and testbench

- Sequences one drink cycle: consumable check, heat, grind, brew, optional creamer and chocolate add.
- Consumes the registered sensor outputs of the sensor interface (levels, paper, pressure, override, fault) and drives the actuator enables.
- Sits between the UI/menu FSM (start, recipe select) and the actuator drivers.

---
 rtl/brew_pkg.sv | 38 +++
 rtl/phase_timer.sv | 27 ++
 rtl/brew_sequencer.sv | 197 +++++++++++++++++++
 tb/tb_brew_sequencer.sv | 381 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/brew_pkg.sv
// Shared types and default timing constants for the brew sequencer.
package brew_pkg;

    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_CHECK = 4'd1,
        S_HEAT  = 4'd2,
        S_GRIND = 4'd3,
        S_BREW  = 4'd4,
        S_CREAM = 4'd5,
        S_CHOC  = 4'd6,
        S_DONE  = 4'd7,
        S_FAULT = 4'd8
    } brew_state_t;

    typedef enum logic [2:0] {
        NONE     = 3'd0,
        PAPER    = 3'd1,
        BIN      = 3'd2,
        CREAM    = 3'd3,
        CHOC     = 3'd4,
        PRESSURE = 3'd5,
        HEAT_TO  = 3'd6,
        SYS      = 3'd7
    } err_code_t;

    localparam logic [7:0] DEF_EMPTY_THRESH  = 8'd10;
    localparam int         DEF_HEAT_TIMEOUT  = 1000;
    localparam int         DEF_GRIND_CYCLES  = 8;
    localparam int         DEF_BREW_CYCLES   = 32;
    localparam int         DEF_ADD_CYCLES    = 4;
    localparam int         DEF_PAUSE_TIMEOUT = 64;

    function automatic int max_of(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/phase_timer.sv
// Loadable saturating down-counter; expired is high once the count reaches zero.
module phase_timer #(
    parameter int W = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_value,
    input  logic         en,
    output logic         expired
);

    logic [W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (en && count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign expired = (count == '0);

endmodule

// File: rtl/brew_sequencer.sv
// Drink-cycle sequencer: consumable check, heat, grind, brew, optional creamer/chocolate.
// Define BREW_SEQ_DRINK_COUNT_EN to add the saturating drink_count output.
module brew_sequencer
    import brew_pkg::*;
#(
    parameter logic [7:0] EMPTY_THRESH  = DEF_EMPTY_THRESH,
    parameter int         HEAT_TIMEOUT  = DEF_HEAT_TIMEOUT,
    parameter int         GRIND_CYCLES  = DEF_GRIND_CYCLES,
    parameter int         BREW_CYCLES   = DEF_BREW_CYCLES,
    parameter int         ADD_CYCLES    = DEF_ADD_CYCLES,
    parameter int         PAUSE_TIMEOUT = DEF_PAUSE_TIMEOUT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       recipe_bin,
    input  logic       recipe_cream,
    input  logic       recipe_choc,
    input  logic       abort,
    input  logic       clear_err,
    input  logic [7:0] bin0_level,
    input  logic [7:0] bin1_level,
    input  logic [7:0] creamer_level,
    input  logic [7:0] chocolate_level,
    input  logic       paper_filter_present,
    input  logic       pressure_ready,
    input  logic       temp_override,
    input  logic       system_fault_flag,
    input  logic       temp_reached,
    output logic       heater_on,
    output logic       grinder_on,
    output logic       pump_on,
    output logic       creamer_valve,
    output logic       choc_valve,
    output logic       grind_bin,
    output logic       busy,
    output logic       done,
    output logic       error,
    output logic [2:0] error_code,
    output logic [3:0] state_out
`ifdef BREW_SEQ_DRINK_COUNT_EN
    ,
    output logic [15:0] drink_count
`endif
);

    localparam int TW = $clog2(max_of(max_of(HEAT_TIMEOUT, GRIND_CYCLES),
                                      max_of(BREW_CYCLES, ADD_CYCLES)) + 1);
    localparam int PW = $clog2(PAUSE_TIMEOUT + 1);

    brew_state_t   state, next_state;
    err_code_t     code_q, fault_code;
    logic          bin_q, cream_q, choc_q, pump_q;
    logic [PW-1:0] pause_cnt;
    logic          timer_load, timer_en, timer_expired;
    logic [TW-1:0] timer_value;
    logic [7:0]    bin_level;

    assign bin_level = bin_q ? bin1_level : bin0_level;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        fault_code = NONE;
        case (state)
            S_IDLE: if (start) next_state = S_CHECK;
            S_CHECK: begin
                if (!paper_filter_present) begin
                    next_state = S_FAULT; fault_code = PAPER;
                end else if (bin_level < EMPTY_THRESH) begin
                    next_state = S_FAULT; fault_code = BIN;
                end else if (cream_q && creamer_level < EMPTY_THRESH) begin
                    next_state = S_FAULT; fault_code = CREAM;
                end else if (choc_q && chocolate_level < EMPTY_THRESH) begin
                    next_state = S_FAULT; fault_code = CHOC;
                end else if (!pressure_ready) begin
                    next_state = S_FAULT; fault_code = PRESSURE;
                end else begin
                    next_state = S_HEAT;
                end
            end
            S_HEAT: begin
                if (temp_reached || temp_override) begin
                    next_state = S_GRIND;
                end else if (timer_expired) begin
                    next_state = S_FAULT; fault_code = HEAT_TO;
                end
            end
            S_GRIND: if (timer_expired) next_state = S_BREW;
            S_BREW: begin
                // Only pumped cycles advance the brew; pauses run a separate watchdog.
                if (pump_q) begin
                    if (timer_expired) begin
                        next_state = cream_q ? S_CREAM : (choc_q ? S_CHOC : S_DONE);
                    end
                end else if (pause_cnt == PW'(PAUSE_TIMEOUT)) begin
                    next_state = S_FAULT; fault_code = PRESSURE;
                end
            end
            S_CREAM: if (timer_expired) next_state = choc_q ? S_CHOC : S_DONE;
            S_CHOC:  if (timer_expired) next_state = S_DONE;
            S_DONE:  next_state = S_IDLE;
            S_FAULT: if (clear_err && !system_fault_flag) next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
        if (state != S_IDLE && state != S_FAULT) begin
            if (system_fault_flag) begin
                next_state = S_FAULT; fault_code = SYS;
            end else if (abort) begin
                next_state = S_IDLE;
            end
        end
    end

    // The timer is reloaded for each new phase with (duration - 1).
    always_comb begin
        timer_load  = (next_state != state);
        timer_value = '0;
        case (next_state)
            S_HEAT:          timer_value = TW'(HEAT_TIMEOUT - 1);
            S_GRIND:         timer_value = TW'(GRIND_CYCLES - 1);
            S_BREW:          timer_value = TW'(BREW_CYCLES - 1);
            S_CREAM, S_CHOC: timer_value = TW'(ADD_CYCLES - 1);
            default:         timer_value = '0;
        endcase
        timer_en = !timer_load &&
                   ((state inside {S_HEAT, S_GRIND, S_CREAM, S_CHOC}) ||
                    (state == S_BREW && pump_q));
    end

    phase_timer #(.W(TW)) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (timer_load),
        .load_value (timer_value),
        .en         (timer_en),
        .expired    (timer_expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            code_q    <= NONE;
            bin_q     <= 1'b0;
            cream_q   <= 1'b0;
            choc_q    <= 1'b0;
            pump_q    <= 1'b0;
            pause_cnt <= '0;
        end else begin
            pump_q <= (next_state == S_BREW) && pressure_ready;
            if (state == S_IDLE && start) begin
                bin_q   <= recipe_bin;
                cream_q <= recipe_cream;
                choc_q  <= recipe_choc;
            end
            if (next_state == S_FAULT && state != S_FAULT) begin
                code_q <= fault_code;
            end else if (state == S_FAULT && next_state == S_IDLE) begin
                code_q <= NONE;
            end
            if (state != S_BREW || pump_q) begin
                pause_cnt <= '0;
            end else if (pause_cnt != PW'(PAUSE_TIMEOUT)) begin
                pause_cnt <= pause_cnt + 1'b1;
            end
        end
    end

`ifdef BREW_SEQ_DRINK_COUNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drink_count <= '0;
        end else if (state == S_DONE && drink_count != 16'hFFFF) begin
            drink_count <= drink_count + 16'd1;
        end
    end
`endif

    assign heater_on     = (state == S_HEAT);
    assign grinder_on    = (state == S_GRIND);
    assign pump_on       = pump_q;
    assign creamer_valve = (state == S_CREAM);
    assign choc_valve    = (state == S_CHOC);
    assign grind_bin     = bin_q;
    assign busy          = (state != S_IDLE);
    assign done          = (state == S_DONE);
    assign error         = (state == S_FAULT);
    assign error_code    = code_q;
    assign state_out     = state;

endmodule

// File: tb/tb_brew_sequencer.sv
// Bench for brew_sequencer: directed scenarios plus random traffic against a cycle model.
module tb_brew_sequencer;
    import brew_pkg::*;

    logic       clk, rst_n, start, recipe_bin, recipe_cream, recipe_choc, abort, clear_err;
    logic [7:0] bin0_level, bin1_level, creamer_level, chocolate_level;
    logic       paper_filter_present, pressure_ready, temp_override, system_fault_flag, temp_reached;
    logic       heater_on, grinder_on, pump_on, creamer_valve, choc_valve;
    logic       grind_bin, busy, done, error;
    logic [2:0] error_code;
    logic [3:0] state_out;
`ifdef BREW_SEQ_DRINK_COUNT_EN
    logic [15:0] drink_count;
`endif

    brew_sequencer dut (
        .clk(clk), .rst_n(rst_n), .start(start), .recipe_bin(recipe_bin),
        .recipe_cream(recipe_cream), .recipe_choc(recipe_choc), .abort(abort),
        .clear_err(clear_err), .bin0_level(bin0_level), .bin1_level(bin1_level),
        .creamer_level(creamer_level), .chocolate_level(chocolate_level),
        .paper_filter_present(paper_filter_present), .pressure_ready(pressure_ready),
        .temp_override(temp_override), .system_fault_flag(system_fault_flag),
        .temp_reached(temp_reached), .heater_on(heater_on), .grinder_on(grinder_on),
        .pump_on(pump_on), .creamer_valve(creamer_valve), .choc_valve(choc_valve),
        .grind_bin(grind_bin), .busy(busy), .done(done), .error(error),
        .error_code(error_code), .state_out(state_out)
`ifdef BREW_SEQ_DRINK_COUNT_EN
        , .drink_count(drink_count)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int errors = 0;
    bit model_on = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: phase plus elapsed-cycle counts, stepped on each clock.
    brew_state_t m_state;
    logic [2:0]  m_code;
    bit          m_bin, m_cream, m_choc, m_pump;
    int          m_elapsed, m_pumped, m_run, m_drinks;

    task automatic model_reset();
        m_state = S_IDLE; m_code = 3'd0; m_bin = 0; m_cream = 0; m_choc = 0; m_pump = 0;
        m_elapsed = 0; m_pumped = 0; m_run = 0; m_drinks = 0;
    endtask

    task automatic model_step();
        brew_state_t nx;
        logic [2:0]  nc;
        logic [7:0]  bl;
        nx = m_state;
        nc = m_code;
        case (m_state)
            S_IDLE: if (start) begin
                m_bin = recipe_bin; m_cream = recipe_cream; m_choc = recipe_choc; nx = S_CHECK;
            end
            S_CHECK: begin
                bl = m_bin ? bin1_level : bin0_level;
                if (!paper_filter_present)                              begin nx = S_FAULT; nc = 3'd1; end
                else if (bl < DEF_EMPTY_THRESH)                         begin nx = S_FAULT; nc = 3'd2; end
                else if (m_cream && creamer_level < DEF_EMPTY_THRESH)   begin nx = S_FAULT; nc = 3'd3; end
                else if (m_choc && chocolate_level < DEF_EMPTY_THRESH)  begin nx = S_FAULT; nc = 3'd4; end
                else if (!pressure_ready)                               begin nx = S_FAULT; nc = 3'd5; end
                else nx = S_HEAT;
            end
            S_HEAT: begin
                m_elapsed++;
                if (temp_reached || temp_override) nx = S_GRIND;
                else if (m_elapsed >= DEF_HEAT_TIMEOUT) begin nx = S_FAULT; nc = 3'd6; end
            end
            S_GRIND: begin
                m_elapsed++;
                if (m_elapsed == DEF_GRIND_CYCLES) nx = S_BREW;
            end
            S_BREW: begin
                if (m_pump) begin
                    m_pumped++; m_run = 0;
                    if (m_pumped == DEF_BREW_CYCLES) nx = m_cream ? S_CREAM : (m_choc ? S_CHOC : S_DONE);
                end else begin
                    m_run++;
                    if (m_run > DEF_PAUSE_TIMEOUT) begin nx = S_FAULT; nc = 3'd5; end
                end
            end
            S_CREAM: begin
                m_elapsed++;
                if (m_elapsed == DEF_ADD_CYCLES) nx = m_choc ? S_CHOC : S_DONE;
            end
            S_CHOC: begin
                m_elapsed++;
                if (m_elapsed == DEF_ADD_CYCLES) nx = S_DONE;
            end
            S_DONE: begin
                nx = S_IDLE;
                if (m_drinks < 65535) m_drinks++;
            end
            S_FAULT: if (clear_err && !system_fault_flag) begin nx = S_IDLE; nc = 3'd0; end
            default: nx = S_IDLE;
        endcase
        if (m_state != S_IDLE && m_state != S_FAULT) begin
            if (system_fault_flag) begin nx = S_FAULT; nc = 3'd7; end
            else if (abort) nx = S_IDLE;
        end
        m_pump = (nx == S_BREW) && pressure_ready;
        if (nx != m_state) begin m_elapsed = 0; m_pumped = 0; m_run = 0; end
        m_state = nx;
        m_code  = nc;
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) model_reset();
        else model_step();
    end

    function automatic logic [15:0] act_vec();
        return {heater_on, grinder_on, pump_on, creamer_valve, choc_valve, grind_bin,
                busy, done, error, error_code, state_out};
    endfunction

    function automatic logic [15:0] exp_vec();
        return {m_state == S_HEAT, m_state == S_GRIND, m_pump, m_state == S_CREAM,
                m_state == S_CHOC, m_bin, m_state != S_IDLE, m_state == S_DONE,
                m_state == S_FAULT, m_code, 4'(m_state)};
    endfunction

    function automatic bit any_act();
        return heater_on | grinder_on | pump_on | creamer_valve | choc_valve;
    endfunction

    always @(negedge clk) begin
        if (rst_n && model_on) begin
            check("model_outputs", 32'(act_vec()), 32'(exp_vec()));
`ifdef BREW_SEQ_DRINK_COUNT_EN
            check("model_drink_count", 32'(drink_count), 32'(m_drinks));
`endif
        end
    end

    task automatic nominal();
        start = 0; recipe_bin = 0; recipe_cream = 0; recipe_choc = 0;
        abort = 0; clear_err = 0; system_fault_flag = 0; temp_reached = 0; temp_override = 1;
        bin0_level = 8'd200; bin1_level = 8'd200; creamer_level = 8'd200; chocolate_level = 8'd200;
        paper_filter_present = 1; pressure_ready = 1;
    endtask

    task automatic pulse_start(input bit b, input bit c, input bit h);
        recipe_bin = b; recipe_cream = c; recipe_choc = h; start = 1;
        @(negedge clk);
        start = 0;
    endtask

    task automatic clear_fault();
        system_fault_flag = 0; clear_err = 1;
        @(negedge clk);
        clear_err = 0;
    endtask

    task automatic pulse_abort();
        abort = 1;
        @(negedge clk);
        abort = 0;
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    initial begin : main
        int k, n, g, p, h, cr, ch, loss;
        bit seen;
        logic [7:0] lv_tab [2];
        lv_tab = '{8'd9, 8'd10};
        nominal();
        rst_n = 0;
        repeat (3) @(negedge clk);
        rst_n = 1; model_on = 1;
        check("reset_outputs", 32'(act_vec()), 32'({12'h000, 4'(S_IDLE)}));

        // Plain coffee, bin0: done 43 cycles after start.
        pulse_start(0, 0, 0);
        k = 1; n = 0; g = 0; p = 0;
        while (n == 0 && k <= 200) begin
            if (grinder_on) g++;
            if (pump_on) p++;
            if (done) n = k;
            @(negedge clk); k++;
        end
        check("plain_done_latency", n, 43);
        check("plain_grind_cycles", g, 8);
        check("plain_pump_cycles", p, 32);

        // Empty selected bin fails in CHECK with no actuator activity.
        bin1_level = 8'd0;
        pulse_start(1, 0, 0);
        k = 1; seen = 0;
        while (!error && k <= 20) begin
            if (any_act()) seen = 1;
            @(negedge clk); k++;
        end
        check("bin_fault_cycle", k, 2);
        check("bin_fault_code", 32'(error_code), 2);
        check("bin_fault_no_actuator", 32'(seen), 0);
        clear_fault();
        check("bin_clear_code", 32'(error_code), 0);
        check("bin_clear_busy", 32'(busy), 0);
        nominal();

        // Threshold boundary: 9 is empty, 10 is not.
        for (int i = 0; i < 2; i++) begin
            bin0_level = lv_tab[i];
            pulse_start(0, 0, 0);
            @(negedge clk);
            check("thresh_error", 32'(error), (i == 0) ? 1 : 0);
            check("thresh_heater", 32'(heater_on), (i == 0) ? 0 : 1);
            if (error) clear_fault();
            else pulse_abort();
        end
        nominal();

        // Ten-cycle pressure dip in BREW delays done by ten.
        pulse_start(0, 0, 0);
        k = 1; n = 0; p = 0;
        while (n == 0 && k <= 200) begin
            if (pump_on) p++;
            if (done) n = k;
            if (k == 20) pressure_ready = 0;
            if (k == 30) pressure_ready = 1;
            @(negedge clk); k++;
        end
        check("dip_done_latency", n, 53);
        check("dip_pump_cycles", p, 32);

        // Sixty-five cycle pressure loss faults with code 5.
        pulse_start(0, 0, 0);
        k = 1;
        while (!error && k <= 300) begin
            if (k == 20) pressure_ready = 0;
            @(negedge clk); k++;
        end
        check("pause_fault_cycle", k, 86);
        check("pause_fault_code", 32'(error_code), 5);
        pressure_ready = 1;
        clear_fault();
        check("pause_clear_code", 32'(error_code), 0);

        // Heat timeout after exactly 1000 HEAT cycles.
        temp_override = 0;
        pulse_start(0, 0, 0);
        k = 1; h = 0;
        while (!error && k <= 1100) begin
            if (heater_on) h++;
            @(negedge clk); k++;
        end
        check("heat_timeout_cycles", h, 1000);
        check("heat_timeout_code", 32'(error_code), 6);
        clear_fault();

        // temp_reached at the fifth HEAT cycle moves to GRIND.
        pulse_start(0, 0, 0);
        k = 1; h = 0;
        while (!grinder_on && k <= 50) begin
            if (heater_on) h++;
            if (k == 6) temp_reached = 1;
            @(negedge clk); k++;
        end
        check("heat_reached_cycles", h, 5);
        check("heat_reached_grind_at", k, 7);
        temp_reached = 0;
        pulse_abort();
        check("grind_abort_idle", 32'(busy), 0);
        nominal();

        // System fault beats abort in GRIND; clear_err ignored while the flag is up.
        pulse_start(0, 0, 0);
        k = 1;
        while (!grinder_on && k <= 50) begin @(negedge clk); k++; end
        system_fault_flag = 1; abort = 1;
        @(negedge clk);
        abort = 0;
        check("sys_fault_error", 32'(error), 1);
        check("sys_fault_code", 32'(error_code), 7);
        clear_err = 1;
        @(negedge clk);
        check("sys_clear_ignored", 32'({error, error_code}), 32'({1'b1, 3'd7}));
        system_fault_flag = 0;
        @(negedge clk);
        clear_err = 0;
        check("sys_cleared", 32'({busy, error_code}), 0);

        // Abort in CREAM: valve off next cycle, no done.
        pulse_start(0, 1, 0);
        k = 1;
        while (!creamer_valve && k <= 100) begin @(negedge clk); k++; end
        check("cream_reached_at", k, 43);
        pulse_abort();
        check("cream_abort_valve", 32'({creamer_valve, busy}), 0);
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            if (done) seen = 1;
            @(negedge clk);
        end
        check("cream_abort_no_done", 32'(seen), 0);

        // Async reset mid-BREW drops the pump immediately.
        pulse_start(0, 0, 0);
        k = 1;
        while (!pump_on && k <= 100) begin @(negedge clk); k++; end
        #2 rst_n = 0;
        #1 check("async_reset_outputs", 32'({pump_on, busy, grind_bin}), 0);
        @(negedge clk);
        rst_n = 1;

        // Cream then chocolate, then done; counter sees exactly one drink.
        pulse_start(1, 1, 1);
        k = 1; n = 0; cr = 0; ch = 0;
        while (n == 0 && k <= 200) begin
            if (creamer_valve) cr++;
            if (choc_valve) begin
                ch++;
                if (cr != 4) check("choc_after_cream", cr, 4);
            end
            if (done) n = k;
            @(negedge clk); k++;
        end
        check("cc_cream_cycles", cr, 4);
        check("cc_choc_cycles", ch, 4);
        check("cc_done_latency", n, 51);
        check("cc_grind_bin", 32'(grind_bin), 1);
`ifdef BREW_SEQ_DRINK_COUNT_EN
        check("cc_drink_count", 32'(drink_count), 1);
`endif

        // Random traffic checked cycle by cycle against the model.
        loss = 0;
        for (int i = 0; i < 4000; i++) begin
            start = ($urandom_range(0, 5) == 0);
            recipe_bin = 1'($urandom_range(0, 1));
            recipe_cream = 1'($urandom_range(0, 1));
            recipe_choc = 1'($urandom_range(0, 1));
            abort = ($urandom_range(0, 249) == 0);
            system_fault_flag = ($urandom_range(0, 299) == 0);
            clear_err = ($urandom_range(0, 3) == 0);
            bin0_level = ($urandom_range(0, 19) == 0) ? 8'($urandom_range(0, 15)) : 8'($urandom_range(10, 255));
            bin1_level = ($urandom_range(0, 19) == 0) ? 8'($urandom_range(0, 15)) : 8'($urandom_range(10, 255));
            creamer_level = ($urandom_range(0, 19) == 0) ? 8'($urandom_range(0, 15)) : 8'($urandom_range(10, 255));
            chocolate_level = ($urandom_range(0, 19) == 0) ? 8'($urandom_range(0, 15)) : 8'($urandom_range(10, 255));
            paper_filter_present = ($urandom_range(0, 39) != 0);
            temp_override = ($urandom_range(0, 7) == 0);
            temp_reached = ($urandom_range(0, 3) == 0);
            if (loss > 0) begin
                loss--; pressure_ready = 0;
            end else if ($urandom_range(0, 79) == 0) begin
                loss = $urandom_range(1, 80); pressure_ready = 0;
            end else begin
                pressure_ready = 1;
            end
            @(negedge clk);
        end
        nominal();
        repeat (2) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
